inference_sequencer: RTL and testbench

- Central scheduler for the single-frame CNN inference chain.
- Launches conv, relu, pool, dense, argmax and UART TX in order.
- Buffers one early-arriving frame, applies a per-stage watchdog and reports status and error.
- Sits between the pixel loader / stage handshakes and the stage start inputs; replaces free-running done-to-start chaining.

---
 rtl/inference_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_inference_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Single-frame CNN inference scheduler: issues stage start pulses in order, queues one early frame
// and guards every stage with a watchdog. Define SEQ_LATENCY_EN to build the last_latency counter.
module inference_sequencer #(
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_loaded,
  input  logic                   conv_done,
  input  logic                   relu_done,
  input  logic                   pool_done,
  input  logic                   flat_done,
  input  logic                   dense_done,
  input  logic                   argmax_done,
  input  logic                   tx_busy,
  input  logic                   clear_err,
  output logic                   conv_start,
  output logic                   relu_start,
  output logic                   pool_start,
  output logic                   dense_start,
  output logic                   argmax_start,
  output logic                   tx_start,
  output logic                   busy,
  output logic                   frame_pending,
  output logic                   error,
  output logic [2:0]             err_stage,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [FRAME_CNT_W-1:0] drop_count,
  output logic [31:0]            last_latency
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CONV    = 4'd1,
    S_RELU    = 4'd2,
    S_POOL    = 4'd3,
    S_FLAT    = 4'd4,
    S_DENSE   = 4'd5,
    S_ARGMAX  = 4'd6,
    S_TX_WAIT = 4'd7,
    S_TX_HOLD = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

  state_t                 state_q, state_d, next_stage;
  logic                   stage_exit, stage_active, entering;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d, wd_inc;
  logic                   seen_busy_q, seen_busy_d;
  logic                   pending_q, pending_d;
  logic                   busy_q, busy_d, error_q, error_d;
  logic [5:0]             start_q, start_d;
  logic [2:0]             err_stage_q, err_stage_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_q, drop_d;

  assign stage_active = (state_q >= S_CONV) && (state_q <= S_TX_HOLD);
  assign wd_inc       = wd_q + TIMEOUT_W'(1);

  // Exit condition and successor of the stage currently running.
  always_comb begin
    stage_exit = 1'b0;
    next_stage = state_q;
    case (state_q)
      S_CONV:    begin stage_exit = conv_done;              next_stage = S_RELU;    end
      S_RELU:    begin stage_exit = relu_done;              next_stage = S_POOL;    end
      S_POOL:    begin stage_exit = pool_done;              next_stage = S_FLAT;    end
      S_FLAT:    begin stage_exit = flat_done;              next_stage = S_DENSE;   end
      S_DENSE:   begin stage_exit = dense_done;             next_stage = S_ARGMAX;  end
      S_ARGMAX:  begin stage_exit = argmax_done;            next_stage = S_TX_WAIT; end
      S_TX_WAIT: begin stage_exit = ~tx_busy;               next_stage = S_TX_HOLD; end
      S_TX_HOLD: begin stage_exit = seen_busy_q & ~tx_busy; next_stage = S_IDLE;    end
      default:   begin stage_exit = 1'b0;                   next_stage = state_q;   end
    endcase
  end

  // Next state, watchdog, frame queue and registered output values.
  always_comb begin
    state_d     = state_q;
    err_stage_d = err_stage_q;
    frame_cnt_d = frame_cnt_q;
    drop_d      = drop_q;
    pending_d   = pending_q;
    seen_busy_d = seen_busy_q;
    start_d     = 6'b000000;

    case (state_q)
      S_IDLE: begin
        if (frame_loaded || pending_q) state_d = S_CONV;
        else state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clear_err) state_d = S_IDLE;
        else state_d = S_ERROR;
      end
      S_CONV, S_RELU, S_POOL, S_FLAT, S_DENSE, S_ARGMAX, S_TX_WAIT, S_TX_HOLD: begin
        // A done arriving on the timeout cycle still counts as a normal exit.
        if (stage_exit) begin
          state_d = next_stage;
        end else if (wd_inc == WD_LAST) begin
          state_d     = S_ERROR;
          err_stage_d = state_q[2:0];
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_TX_HOLD) && stage_exit) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    else frame_cnt_d = frame_cnt_q;

    // Leaving IDLE on a queued frame consumes it; a frame arriving that cycle takes its place.
    if (state_q == S_IDLE) begin
      if (pending_q) pending_d = frame_loaded;
      else pending_d = 1'b0;
    end else if (frame_loaded) begin
      if (pending_q) begin
        if (drop_q != {FRAME_CNT_W{1'b1}}) drop_d = drop_q + FRAME_CNT_W'(1);
        else drop_d = drop_q;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end

    entering = (state_d != state_q);

    if (entering) wd_d = {TIMEOUT_W{1'b0}};
    else if (stage_active) wd_d = wd_inc;
    else wd_d = {TIMEOUT_W{1'b0}};

    if (entering && (state_d == S_TX_HOLD)) seen_busy_d = 1'b0;
    else if ((state_q == S_TX_HOLD) && tx_busy) seen_busy_d = 1'b1;
    else seen_busy_d = seen_busy_q;

    if (entering) begin
      case (state_d)
        S_CONV:    start_d = 6'b000001;
        S_RELU:    start_d = 6'b000010;
        S_POOL:    start_d = 6'b000100;
        S_DENSE:   start_d = 6'b001000;
        S_ARGMAX:  start_d = 6'b010000;
        S_TX_HOLD: start_d = 6'b100000;
        default:   start_d = 6'b000000;
      endcase
    end else begin
      start_d = 6'b000000;
    end

    busy_d  = (state_d >= S_CONV) && (state_d <= S_TX_HOLD);
    error_d = (state_d == S_ERROR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wd_q        <= {TIMEOUT_W{1'b0}};
      seen_busy_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      start_q     <= 6'b000000;
      err_stage_q <= 3'd0;
      frame_cnt_q <= {FRAME_CNT_W{1'b0}};
      drop_q      <= {FRAME_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      seen_busy_q <= seen_busy_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      start_q     <= start_d;
      err_stage_q <= err_stage_d;
      frame_cnt_q <= frame_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign conv_start    = start_q[0];
  assign relu_start    = start_q[1];
  assign pool_start    = start_q[2];
  assign dense_start   = start_q[3];
  assign argmax_start  = start_q[4];
  assign tx_start      = start_q[5];
  assign busy          = busy_q;
  assign frame_pending = pending_q;
  assign error         = error_q;
  assign err_stage     = err_stage_q;
  assign frame_count   = frame_cnt_q;
  assign drop_count    = drop_q;

`ifdef SEQ_LATENCY_EN
  logic [31:0] lat_q, lat_d, lat_inc, last_lat_q, last_lat_d;

  // Busy-cycle count of the frame in flight, published when the frame completes.
  always_comb begin
    lat_inc = (lat_q == 32'hFFFF_FFFF) ? lat_q : lat_q + 32'd1;
    if ((state_q == S_IDLE) && (state_d == S_CONV)) lat_d = 32'd0;
    else if (stage_active) lat_d = lat_inc;
    else lat_d = lat_q;
    if ((state_q == S_TX_HOLD) && (state_d == S_IDLE)) last_lat_d = lat_inc;
    else last_lat_d = last_lat_q;
  end

  // Latency registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_q      <= 32'd0;
      last_lat_q <= 32'd0;
    end else begin
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign last_latency = last_lat_q;
`else
  assign last_latency = 32'd0;
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomized scoreboard bench for inference_sequencer: a transaction-level model predicts every
// output for the following cycle; a monitor pops each prediction and compares it with the DUT.
module tb_inference_sequencer;
  localparam int TO = 16;
  localparam int FW = 16;
  localparam int IDLE_S = -1;
  localparam int ERR_S = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0, frame_loaded = 1'b0, conv_done = 1'b0, relu_done = 1'b0, pool_done = 1'b0;
  logic flat_done = 1'b0, dense_done = 1'b0, argmax_done = 1'b0, tx_busy = 1'b0, clear_err = 1'b0;
  logic conv_start, relu_start, pool_start, dense_start, argmax_start, tx_start;
  logic busy, frame_pending, error;
  logic [2:0] err_stage;
  logic [FW-1:0] frame_count, drop_count;
  logic [31:0] last_latency;

  inference_sequencer #(.TIMEOUT_W(24), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(FW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_loaded(frame_loaded),
    .conv_done(conv_done), .relu_done(relu_done), .pool_done(pool_done), .flat_done(flat_done),
    .dense_done(dense_done), .argmax_done(argmax_done), .tx_busy(tx_busy), .clear_err(clear_err),
    .conv_start(conv_start), .relu_start(relu_start), .pool_start(pool_start),
    .dense_start(dense_start), .argmax_start(argmax_start), .tx_start(tx_start),
    .busy(busy), .frame_pending(frame_pending), .error(error), .err_stage(err_stage),
    .frame_count(frame_count), .drop_count(drop_count), .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    starts;  // {tx, argmax, dense, pool, relu, conv}
    logic          busy, pending, error;
    logic [2:0]    err_stage;
    logic [FW-1:0] frames, drops;
    logic [31:0]   last_lat;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Chain positions: 0 conv,1 relu,2 pool,3 flat,4 dense,5 argmax,6 tx wait,7 tx hold; -1 idle; 8 error.
  int start_bit[8] = '{0, 1, 2, -1, 3, 4, -1, 5};
  int m_stage, m_age, m_err_code, m_frames, m_drops, m_lat, m_last;
  bit m_pend, m_seen;

  int knob_delay = 5, knob_withhold = -1, knob_fl_rate = 0, knob_tx_wait = 0, knob_tx_high = 10;
  bit knob_noise = 1'b0, knob_rand_to = 1'b0;
  int cur_delay, cur_lo, cur_hi;

  function automatic void pick();
    int r;
    cur_delay = 1000; cur_lo = 1; cur_hi = 0;
    r = int'($urandom_range(0, 19));
    if (m_stage >= 0 && m_stage <= 5) begin
      if (m_stage == knob_withhold || (knob_rand_to && r == 0)) cur_delay = 1000;
      else if (knob_delay > 0) cur_delay = knob_delay;
      else if (r == 1) cur_delay = TO - 2;
      else cur_delay = int'($urandom_range(0, 8));
    end else if (m_stage == 6) begin
      if (knob_rand_to && r == 0) cur_hi = 1000;
      else if (knob_tx_wait >= 0) cur_hi = knob_tx_wait;
      else if (r == 1) cur_hi = TO - 2;
      else cur_hi = int'($urandom_range(0, 6));
    end else if (m_stage == 7) begin
      cur_lo = (knob_tx_high >= 0) ? 1 : int'($urandom_range(1, 3));
      if (knob_rand_to && r == 0) cur_hi = 1000;
      else if (knob_tx_high >= 0) cur_hi = knob_tx_high;
      else cur_hi = int'($urandom_range(1, 9));
    end
  endfunction

  // Reference model: applies one cycle of inputs and predicts the outputs of the next cycle.
  function automatic void model_step(input bit rst, input bit fl, input logic [5:0] dn,
                                     input bit tb, input bit ce);
    exp_t e;
    int nxt;
    bit ok;
    e.starts = 6'b000000;
    if (rst) begin
      m_stage = IDLE_S; m_age = 0; m_pend = 1'b0; m_seen = 1'b0; m_err_code = 0;
      m_frames = 0; m_drops = 0; m_lat = 0; m_last = 0;
    end else begin
      nxt = m_stage;
      if (m_stage == IDLE_S) begin
        if (m_pend || fl) nxt = 0;
        if (m_pend) m_pend = fl;
      end else if (fl) begin
        if (m_pend) m_drops = (m_drops == 65535) ? m_drops : m_drops + 1;
        else m_pend = 1'b1;
      end
      if (m_stage >= 0 && m_stage <= 7) begin
        if (m_stage <= 5) ok = dn[m_stage];
        else if (m_stage == 6) ok = !tb;
        else ok = m_seen && !tb;
        m_lat = m_lat + 1;
        if (ok) begin
          if (m_stage == 7) begin
            nxt = IDLE_S; m_frames = (m_frames + 1) % 65536; m_last = m_lat;
          end else nxt = m_stage + 1;
        end else if (m_age == TO - 1) begin
          nxt = ERR_S; m_err_code = (m_stage + 1) % 8;
        end
        if (m_stage == 7 && tb) m_seen = 1'b1;
      end else if (m_stage == ERR_S && ce) nxt = IDLE_S;
      if (m_stage == IDLE_S && nxt == 0) m_lat = 0;
      if (nxt != m_stage) begin
        if (nxt >= 0 && nxt <= 7 && start_bit[nxt] >= 0) e.starts[start_bit[nxt]] = 1'b1;
        if (nxt == 7) m_seen = 1'b0;
        m_stage = nxt; m_age = 1;
        pick();
      end else m_age = m_age + 1;
    end
    e.busy = (m_stage >= 0 && m_stage <= 7);
    e.pending = m_pend;
    e.error = (m_stage == ERR_S);
    e.err_stage = 3'(m_err_code);
    e.frames = FW'(m_frames);
    e.drops = FW'(m_drops);
`ifdef SEQ_LATENCY_EN
    e.last_lat = 32'(m_last);
`else
    e.last_lat = 32'd0;
`endif
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input bit rst, input bit fl_force, input logic [5:0] dn_force);
    logic [5:0] dn;
    bit fl, tb, ce;
    int k;
    @(negedge clk);
    dn = dn_force; tb = 1'b0; ce = 1'b0;
    fl = fl_force || (knob_fl_rate > 0 && int'($urandom_range(1, knob_fl_rate)) == 1);
    if (!rst) begin
      if (m_stage >= 0 && m_stage <= 5 && m_age == cur_delay + 1) dn[m_stage] = 1'b1;
      if (knob_noise && $urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, 5));
        if (k != m_stage) dn[k] = 1'b1;
      end
      if (m_stage == 6) tb = (m_age <= cur_hi);
      else if (m_stage == 7) tb = (m_age > cur_lo) && (m_age <= cur_lo + cur_hi);
      if (m_stage == ERR_S) ce = (m_age == 3);
      else if (knob_noise) ce = ($urandom_range(0, 19) == 0);
    end
    reset_n = !rst; frame_loaded = fl; clear_err = ce; tx_busy = tb;
    conv_done = dn[0]; relu_done = dn[1]; pool_done = dn[2];
    flat_done = dn[3]; dense_done = dn[4]; argmax_done = dn[5];
    model_step(rst, fl, dn, tb, ce);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 6'b000000);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one prediction per cycle, compared just after the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk("starts", 32'({tx_start, argmax_start, dense_start, pool_start, relu_start, conv_start}),
            32'(e.starts));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("frame_pending", 32'(frame_pending), 32'(e.pending));
        chk("error", 32'(error), 32'(e.error));
        chk("err_stage", 32'(err_stage), 32'(e.err_stage));
        chk("frame_count", 32'(frame_count), 32'(e.frames));
        chk("drop_count", 32'(drop_count), 32'(e.drops));
        chk("last_latency", last_latency, e.last_lat);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'b000000);
    run(6);
    // single frame, fixed timing
    cycle(1'b0, 1'b1, 6'b000000);
    run(70);
    // back-to-back: one frame starts, two more arrive during CONV
    cycle(1'b0, 1'b1, 6'b000000);
    cycle(1'b0, 1'b1, 6'b000000);
    cycle(1'b0, 1'b1, 6'b000000);
    run(150);
    // watchdog on dense, then clear_err
    knob_withhold = 4;
    cycle(1'b0, 1'b1, 6'b000000);
    run(70);
    knob_withhold = -1;
    // tx gating: tx_busy high for the first 10 TX_WAIT cycles
    knob_tx_wait = 10;
    cycle(1'b0, 1'b1, 6'b000000);
    run(80);
    knob_tx_wait = 0;
    // reset mid-POOL, then a stale pool_done, then a clean restart
    cycle(1'b0, 1'b1, 6'b000000);
    for (int i = 0; i < 100 && m_stage != 2; i++) cycle(1'b0, 1'b0, 6'b000000);
    cycle(1'b0, 1'b0, 6'b000000);
    cycle(1'b1, 1'b0, 6'b000000);
    cycle(1'b0, 1'b0, 6'b000100);
    run(5);
    cycle(1'b0, 1'b1, 6'b000000);
    run(70);
    // randomized traffic with timeouts, overruns and spurious pulses
    knob_delay = 0; knob_tx_wait = -1; knob_tx_high = -1;
    knob_noise = 1'b1; knob_rand_to = 1'b1; knob_fl_rate = 25;
    run(3000);
    knob_noise = 1'b0; knob_rand_to = 1'b0; knob_fl_rate = 0;
    run(2);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked predictions, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
